rf_wb_arbiter: RTL and testbench
================================

// Module: rf_wb_arbiter
// PURPOSE
//   Shares the single register-file write port between NREQ writeback sources
//   (e.g. ALU result, load data, link address) with round-robin arbitration.
//   Also keeps a pending-write scoreboard so issue logic can stall on RAW hazards.
//   Sits between the writeback sources and the register file write port
//   (rf_wen / rf_addr_w / rf_data_w). The register file samples that port on the negedge.
// PARAMETERS
//   NREQ  3   number of writeback requesters (2..8)
//   DW    32  data width
//   AW    5   register address width (2**AW registers, reg 0 hard-wired zero)
// PORTS
//   clk          in   1         system clock; all state updates on posedge
//   rst_n        in   1         asynchronous, active-low reset
//   req_valid    in   NREQ      requester i has a write pending
//   req_addr     in   NREQ*AW   dest reg of requester i, bits [i*AW +: AW]
//   req_data     in   NREQ*DW   write data of requester i, bits [i*DW +: DW]
//   req_ready    out  NREQ      one-hot grant; transfer when valid & ready
//   sb_set       in   1         issue stage allocates a pending write
//   sb_set_addr  in   AW        dest reg being allocated
//   sb_busy      out  2**AW     bit r = 1: write to reg r outstanding
//   rf_wen       out  1         RF write enable (registered)
//   rf_addr_w    out  AW        RF write address (registered)
//   rf_data_w    out  DW        RF write data (registered)
// BEHAVIOUR
//   Reset (async, rst_n=0)
//   - rf_wen=0, rf_addr_w=0, rf_data_w=0, sb_busy=0, rr pointer=0.
//   - req_ready=0 while rst_n=0.
//   - Reset mid-transfer drops the in-flight write; no partial write reaches the RF.
//   Arbitration (combinational, same cycle)
//   - Grant the first i with req_valid[i], searching ptr, ptr+1, ... (mod NREQ).
//   - req_ready is one-hot or zero; at most one transfer per cycle.
//   - An ungranted requester must hold valid/addr/data stable until ready.
//   - On a transfer, ptr <= (granted index + 1) mod NREQ. With no transfer, ptr holds.
//   - Starvation bound: a held request is granted within NREQ cycles.
//   Write port (latency 1)
//   - Transfer in cycle N: at posedge N+1, rf_wen=1 and addr/data are captured
//     from the winner. They are stable at the following negedge.
//   - No transfer: rf_wen=0 next cycle; addr/data hold their last value.
//   - Write to reg 0: accepted (ready=1) but rf_wen stays 0; sb_busy[0] is never set.
//   - Back-to-back transfers are allowed every cycle; no bubbles are required.
//   Scoreboard
//   - sb_set with addr!=0 sets sb_busy[addr] at next posedge.
//   - A transfer to addr clears sb_busy[addr] at the same posedge that rf_wen rises.
//   - Set and clear on the same reg in the same cycle: set wins (newer writer pending).
//   - Clear of a non-busy reg is harmless. sb_busy[0] is constantly 0.
//   - Set of an already-busy reg keeps it busy (no counting; issue must not
//     double-allocate).
// TESTING
//   1 Reset: assert rst_n=0 mid-transfer
//     -> all outputs 0 immediately, no RF write after release.
//   2 Single source: req_valid=3'b001, addr=5, data=32'hDEADBEEF
//     -> ready[0] same cycle; rf_wen=1, rf_addr_w=5, data=DEADBEEF next cycle.
//   3 Round-robin: all 3 valid for 6 cycles
//     -> grants 0,1,2,0,1,2; rf_wen high 6 consecutive cycles.
//   4 Reg 0: requester 1 writes addr 0, data 32'h1234
//     -> ready[1]=1, rf_wen stays 0, sb_busy unchanged.
//   5 Scoreboard: sb_set addr 7, then transfer addr 7 in the same cycle as
//     sb_set addr 7 -> sb_busy[7]=1 afterwards; later a lone transfer clears it.
//   6 Fairness: req 0 held continuously, req 2 raised
//     -> req 2 granted within 3 cycles; pointer wraps 2 -> 0.

Source files
------------

// File: rtl/rf_wb_arbiter_if.sv
// Writeback request bus between the NREQ writeback sources and the arbiter.
// Handshake: a requester raises req_valid[i] with req_addr/req_data slice i;
// a transfer happens in any cycle where req_valid[i] & req_ready[i]. An
// ungranted requester keeps valid/addr/data stable until it sees ready.
// req_ready is one-hot or zero and is combinational in the same cycle.
interface rf_wb_arbiter_if #(
  parameter int NREQ = 3,
  parameter int DW   = 32,
  parameter int AW   = 5
) ();
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;

  // Writeback source side
  modport master (
    output req_valid,
    output req_addr,
    output req_data,
    input  req_ready
  );

  // Arbiter side
  modport slave (
    input  req_valid,
    input  req_addr,
    input  req_data,
    output req_ready
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between NREQ
// writeback sources, with a pending-write scoreboard for RAW stall detection.
// The winner's address/data are registered (latency 1) so the register file
// sees a stable port at the following negedge.
module rf_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int DW   = 32,
  parameter int AW   = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rf_wb_arbiter_if.slave       req,
  input  logic                 sb_set,
  input  logic [AW-1:0]        sb_set_addr,
  output logic [(1<<AW)-1:0]   sb_busy,
  output logic                 rf_wen,
  output logic [AW-1:0]        rf_addr_w,
  output logic [DW-1:0]        rf_data_w
);

  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int NREG = 1 << AW;

  // Round-robin pointer: index searched first in the current cycle.
  logic [PW-1:0]   ptr;

  logic [NREQ-1:0] grant;
  logic [PW-1:0]   grant_idx;
  logic            grant_found;
  int              scan_idx;

  logic            transfer;
  logic [AW-1:0]   win_addr;
  logic [DW-1:0]   win_data;
  logic            win_writes;
  logic [PW-1:0]   ptr_next;
  logic [NREG-1:0] sb_next;

  // Priority search starting at ptr and wrapping modulo NREQ.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_found = 1'b0;
    scan_idx    = 0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = int'(ptr) + k;
      if (scan_idx >= NREQ) scan_idx = scan_idx - NREQ;
      if (!grant_found && req.req_valid[scan_idx]) begin
        grant[scan_idx] = 1'b1;
        grant_idx       = PW'(scan_idx);
        grant_found     = 1'b1;
      end
    end
  end

  // Ready is forced low while reset is asserted so nothing is accepted then.
  assign req.req_ready = rst_n ? grant : '0;
  assign transfer      = rst_n && grant_found;

  assign win_addr   = req.req_addr[grant_idx*AW +: AW];
  assign win_data   = req.req_data[grant_idx*DW +: DW];
  // Writes to register 0 are accepted but never reach the register file.
  assign win_writes = transfer && (win_addr != '0);

  // Pointer advances to the slot after the winner, wrapping at NREQ-1.
  always_comb begin
    ptr_next = ptr;
    if (transfer) begin
      if (grant_idx == PW'(NREQ - 1)) ptr_next = '0;
      else                            ptr_next = grant_idx + PW'(1);
    end
  end

  // Scoreboard update: clear on retirement, then set so a new allocation of
  // the same register in the same cycle stays pending.
  always_comb begin
    sb_next = sb_busy;
    if (win_writes) sb_next[win_addr] = 1'b0;
    if (sb_set && (sb_set_addr != '0)) sb_next[sb_set_addr] = 1'b1;
    sb_next[0] = 1'b0;
  end

  // Arbitration pointer and scoreboard state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr     <= '0;
      sb_busy <= '0;
    end else begin
      ptr     <= ptr_next;
      sb_busy <= sb_next;
    end
  end

  // Registered write port; address/data hold when nothing is written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_wen    <= 1'b0;
      rf_addr_w <= '0;
      rf_data_w <= '0;
    end else begin
      rf_wen <= win_writes;
      if (win_writes) begin
        rf_addr_w <= win_addr;
        rf_data_w <= win_data;
      end
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: reset corner case, a table of directed vectors,
// then randomized traffic checked against a queue-free behavioural model.
module tb_rf_wb_arbiter;
  localparam int NREQ = 3;
  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int NREG = 1 << AW;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rf_wb_arbiter_if #(.NREQ(NREQ), .DW(DW), .AW(AW)) bus ();

  logic            sb_set;
  logic [AW-1:0]   sb_set_addr;
  logic [NREG-1:0] sb_busy;
  logic            rf_wen;
  logic [AW-1:0]   rf_addr_w;
  logic [DW-1:0]   rf_data_w;

  rf_wb_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (bus),
    .sb_set      (sb_set),
    .sb_set_addr (sb_set_addr),
    .sb_busy     (sb_busy),
    .rf_wen      (rf_wen),
    .rf_addr_w   (rf_addr_w),
    .rf_data_w   (rf_data_w)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Driver: apply inputs at negedge, sample ready mid-cycle, then let the
  // posedge happen and settle so registered outputs can be read.
  task automatic step(input logic [NREQ-1:0] v, input logic [NREQ*AW-1:0] a,
                      input logic [NREQ*DW-1:0] d, input logic s,
                      input logic [AW-1:0] sa, output logic [NREQ-1:0] rdy);
    @(negedge clk);
    bus.req_valid = v;
    bus.req_addr  = a;
    bus.req_data  = d;
    sb_set        = s;
    sb_set_addr   = sa;
    #1 rdy = bus.req_ready;
    @(posedge clk);
    #1;
  endtask

  // Directed vector table
  typedef struct {
    string            name;
    logic [NREQ-1:0]  v;
    logic [NREQ*AW-1:0] a;
    logic [NREQ*DW-1:0] d;
    logic             s;
    logic [AW-1:0]    sa;
    logic [NREQ-1:0]  er;
    logic             ewen;
    logic             chk_ad;
    logic [AW-1:0]    ea;
    logic [DW-1:0]    ed;
    logic [NREG-1:0]  eb;
  } row_t;

  row_t rows[$];

  task automatic add(input string name, input logic [2:0] v,
                     input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
                     input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                     input logic s, input logic [4:0] sa, input logic [2:0] er,
                     input logic ewen, input logic chk_ad, input logic [4:0] ea,
                     input logic [31:0] ed, input logic [31:0] eb);
    row_t r;
    r.name = name; r.v = v; r.a = {a2, a1, a0}; r.d = {d2, d1, d0};
    r.s = s; r.sa = sa; r.er = er; r.ewen = ewen; r.chk_ad = chk_ad;
    r.ea = ea; r.ed = ed; r.eb = eb;
    rows.push_back(r);
  endtask

  // Behavioural model state for the random phase
  int               m_ptr;
  logic [NREG-1:0]  m_busy;
  logic             pend [NREQ];
  logic [AW-1:0]    pa   [NREQ];
  logic [DW-1:0]    pd   [NREQ];
  int               wt   [NREQ];

  logic [NREQ-1:0]  rdy;
  logic [NREQ*AW-1:0] va;
  logic [NREQ*DW-1:0] vd;
  logic [NREQ-1:0]  vv;

  initial begin
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    sb_set        = 1'b0;
    sb_set_addr   = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", bus.req_ready, 0);
    chk("reset_wen", rf_wen, 0);
    chk("reset_addr", rf_addr_w, 0);
    chk("reset_data", rf_data_w, 0);
    chk("reset_busy", sb_busy, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset mid-transfer
    step(3'b001, {5'd0, 5'd0, 5'd4}, {32'd0, 32'd0, 32'h44}, 1'b1, 5'd3, rdy);
    chk("rst_pre_ready", rdy, 3'b001);
    chk("rst_pre_wen", rf_wen, 1);
    chk("rst_pre_addr", rf_addr_w, 4);
    chk("rst_pre_busy", sb_busy, 32'h8);
    @(negedge clk);
    bus.req_addr = {5'd0, 5'd0, 5'd6};
    bus.req_data = {32'd0, 32'd0, 32'h66};
    sb_set = 1'b0;
    #1 chk("rst_inflight_ready", bus.req_ready, 3'b001);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_async_ready", bus.req_ready, 0);
    chk("rst_async_wen", rf_wen, 0);
    chk("rst_async_addr", rf_addr_w, 0);
    chk("rst_async_data", rf_data_w, 0);
    chk("rst_async_busy", sb_busy, 0);
    @(posedge clk);
    #1 chk("rst_hold_wen", rf_wen, 0);
    @(negedge clk);
    bus.req_valid = '0;
    rst_n = 1'b1;
    step('0, '0, '0, 1'b0, '0, rdy);
    chk("rst_release_wen", rf_wen, 0);
    chk("rst_release_addr", rf_addr_w, 0);
    step('0, '0, '0, 1'b0, '0, rdy);
    chk("rst_release_wen2", rf_wen, 0);

    // Directed table (pointer starts at 0 after reset)
    for (int i = 0; i < 2; i++) begin
      add("rr0", 3'b111, 5'd1, 5'd2, 5'd3, 32'hA0, 32'hA1, 32'hA2, 0, 0, 3'b001, 1, 1, 5'd1, 32'hA0, 0);
      add("rr1", 3'b111, 5'd1, 5'd2, 5'd3, 32'hA0, 32'hA1, 32'hA2, 0, 0, 3'b010, 1, 1, 5'd2, 32'hA1, 0);
      add("rr2", 3'b111, 5'd1, 5'd2, 5'd3, 32'hA0, 32'hA1, 32'hA2, 0, 0, 3'b100, 1, 1, 5'd3, 32'hA2, 0);
    end
    add("single",   3'b001, 5'd5, 0, 0, 32'hDEADBEEF, 0, 0, 0, 0, 3'b001, 1, 1, 5'd5, 32'hDEADBEEF, 0);
    add("idle",     3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 1, 5'd5, 32'hDEADBEEF, 0);
    add("reg0",     3'b010, 0, 5'd0, 0, 0, 32'h1234, 0, 0, 0, 3'b010, 0, 0, 0, 0, 0);
    add("sb_set",   3'b000, 0, 0, 0, 0, 0, 0, 1, 5'd7, 3'b000, 0, 1, 5'd5, 32'hDEADBEEF, 32'h80);
    add("sb_both",  3'b100, 0, 0, 5'd7, 0, 0, 32'h77, 1, 5'd7, 3'b100, 1, 1, 5'd7, 32'h77, 32'h80);
    add("sb_clear", 3'b001, 5'd7, 0, 0, 32'h88, 0, 0, 0, 0, 3'b001, 1, 1, 5'd7, 32'h88, 0);
    add("fair0",    3'b001, 5'd9, 0, 0, 32'h900, 0, 0, 0, 0, 3'b001, 1, 1, 5'd9, 32'h900, 0);
    add("fair1",    3'b101, 5'd9, 0, 5'd10, 32'h900, 0, 32'hA00, 0, 0, 3'b100, 1, 1, 5'd10, 32'hA00, 0);
    add("fair_wrap",3'b101, 5'd9, 0, 5'd10, 32'h900, 0, 32'hA00, 0, 0, 3'b001, 1, 1, 5'd9, 32'h900, 0);
    add("fair3",    3'b101, 5'd9, 0, 5'd10, 32'h900, 0, 32'hA00, 0, 0, 3'b100, 1, 1, 5'd10, 32'hA00, 0);

    foreach (rows[i]) begin
      step(rows[i].v, rows[i].a, rows[i].d, rows[i].s, rows[i].sa, rdy);
      chk({rows[i].name, "_ready"}, rdy, rows[i].er);
      chk({rows[i].name, "_wen"}, rf_wen, rows[i].ewen);
      if (rows[i].chk_ad) begin
        chk({rows[i].name, "_addr"}, rf_addr_w, rows[i].ea);
        chk({rows[i].name, "_data"}, rf_data_w, rows[i].ed);
      end
      chk({rows[i].name, "_busy"}, sb_busy, rows[i].eb);
    end

    // Randomized traffic against the model (pointer is back at 0 here)
    m_ptr  = 0;
    m_busy = '0;
    for (int i = 0; i < NREQ; i++) begin
      pend[i] = 1'b0; pa[i] = '0; pd[i] = '0; wt[i] = 0;
    end
    for (int c = 0; c < 2000; c++) begin
      int g;
      logic s;
      logic [AW-1:0] sa;
      logic ew;
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
          pend[i] = 1'b1;
          pa[i]   = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom_range(1, NREG - 1));
          pd[i]   = $urandom;
          wt[i]   = 0;
        end
        vv[i]            = pend[i];
        va[i*AW +: AW]   = pa[i];
        vd[i*DW +: DW]   = pd[i];
      end
      s  = ($urandom_range(0, 2) == 0);
      sa = AW'($urandom_range(0, NREG - 1));

      // Round-robin rule: first pending index at or after the pointer.
      g = -1;
      for (int k = 0; k < NREQ; k++) begin
        int idx;
        idx = (m_ptr + k) % NREQ;
        if (g < 0 && pend[idx]) g = idx;
      end

      step(vv, va, vd, s, sa, rdy);
      chk("rand_ready", rdy, (g < 0) ? 0 : (1 << g));
      ew = (g >= 0) && (pa[g] != 0);
      chk("rand_wen", rf_wen, ew);
      if (ew) begin
        chk("rand_addr", rf_addr_w, pa[g]);
        chk("rand_data", rf_data_w, pd[g]);
      end
      if (g >= 0) chk("rand_starve", (wt[g] < NREQ), 1);

      if (ew) m_busy[pa[g]] = 1'b0;
      if (s && sa != 0) m_busy[sa] = 1'b1;
      chk("rand_busy", sb_busy, m_busy);

      for (int i = 0; i < NREQ; i++) if (pend[i] && i != g) wt[i]++;
      if (g >= 0) begin
        pend[g] = 1'b0;
        m_ptr   = (g + 1) % NREQ;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
